// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key-schedule engine: expands the cipher key one word per clock into a
// word buffer, then serves any round key through a registered read port.
module aes_key_schedule #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [KEY_BITS-1:0] key_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic [3:0]          rk_idx_i,
    output logic [127:0]        round_key_o,
    output logic                rk_valid_o
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] LAST_W   = 6'(NW - 1);
    localparam logic [5:0] FIRST_W  = 6'(NK);
    localparam logic [2:0] MOD_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_IDX   = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_t                state_q;
    logic [KEY_BITS-1:0]   key_q;
    logic [31:0]           win_q [NK];
    logic [31:0]           wbuf_q [NW];
    logic [5:0]            i_q;
    logic [2:0]            mod_q;
    logic [7:0]            rcon_q;
    logic                  busy_q;
    logic                  done_q;
    logic [127:0]          round_key_q;
    logic                  rk_valid_q;

    logic [31:0]           prev_w;
    logic [31:0]           rot_w;
    logic [31:0]           sub_in;
    logic [31:0]           sub_w;
    logic [31:0]           temp_w;
    logic [31:0]           word_d;
    logic                  rk_in_range;
    logic [3:0]            rk_sel;
    logic [5:0]            rd_base;
    logic [127:0]          rd_row_d;

    // win_q holds the last NK words, w[i-NK] at index 0 and w[i-1] at index NK-1.
    assign prev_w = win_q[NK-1];
    assign rot_w  = {prev_w[23:0], prev_w[31:24]};
    assign sub_in = (mod_q == 3'd0) ? rot_w : prev_w;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_w[8*gi +: 8] = sbox(sub_in[8*gi +: 8]);
        end
    endgenerate

    always_comb begin
        temp_w = prev_w;
        if (mod_q == 3'd0) begin
            temp_w = sub_w ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && mod_q == 3'd4) begin
            temp_w = sub_w;
        end
        word_d = win_q[0] ^ temp_w;
    end

    assign rk_in_range = (rk_idx_i <= NR_IDX);
    assign rk_sel      = rk_in_range ? rk_idx_i : 4'd0;
    assign rd_base     = {rk_sel, 2'b00};
    assign rd_row_d    = {wbuf_q[rd_base], wbuf_q[rd_base + 6'd1],
                          wbuf_q[rd_base + 6'd2], wbuf_q[rd_base + 6'd3]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            for (int j = 0; j < NK; j++) win_q[j] <= '0;
            i_q         <= 6'd0;
            mod_q       <= 3'd0;
            rcon_q      <= 8'h01;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            round_key_q <= '0;
            rk_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        key_q   <= key_i;
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    for (int j = 0; j < NK; j++) win_q[j] <= key_q[KEY_BITS-1-32*j -: 32];
                    i_q     <= FIRST_W;
                    mod_q   <= 3'd0;
                    rcon_q  <= 8'h01;
                    state_q <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    for (int j = 0; j < NK - 1; j++) win_q[j] <= win_q[j+1];
                    win_q[NK-1] <= word_d;
                    if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
                    mod_q <= (mod_q == MOD_LAST) ? 3'd0 : mod_q + 3'd1;
                    i_q   <= i_q + 6'd1;
                    if (i_q == LAST_W) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A start accepted in DONE invalidates reads from the same edge onward.
            if (done_q && !start_i) begin
                rk_valid_q  <= rk_in_range;
                round_key_q <= rk_in_range ? rd_row_d : '0;
            end else begin
                rk_valid_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ST_LOAD) begin
            for (int j = 0; j < NK; j++) wbuf_q[j] <= key_q[KEY_BITS-1-32*j -: 32];
        end else if (state_q == ST_EXPAND) begin
            wbuf_q[i_q] <= word_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign round_key_o = round_key_q;
    assign rk_valid_o  = rk_valid_q;

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Parametrised AES key-schedule engine covering AES-128/192/256.
- Expands a cipher key into all Nr+1 round keys, one 32-bit word per clock, using four shared S-box lookups.
- Stores the expanded schedule in an internal word buffer and serves any round key through a registered read port.
- Sits between the SPI key-load path and the cipher core, replacing per-round on-the-fly expansion so decryption can read round keys in reverse order.

Parameters:
- KEY_BITS, 128, cipher key length; legal values 128, 192, 256, any other value is a static error.
- Derived localparams: NK = KEY_BITS/32 (4/6/8); NR = NK+6 (10/12/14); NW = 4*(NR+1) (44/52/60).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin expansion of key.
- key  in  KEY_BITS  cipher key, MSB = first byte; sampled only on an accepted start.
- busy  out  1  high while loading/expanding.
- done  out  1  high while a complete schedule is held.
- rk_idx  in  4  round-key index to read, 0..NR.
- round_key  out  128  round key rk_idx, registered; word w[4*idx] in bits 127:96.
- rk_valid  out  1  round_key is valid for the index presented the previous cycle.

Behaviour:
- Reset (asynchronous, while reset=0): state IDLE; busy=0, done=0, rk_valid=0, round_key=0, word counter=0, rcon=8'h01. Buffer contents are don't-care.
- FSM states: IDLE -> LOAD -> EXPAND -> DONE.
- IDLE/DONE + start=1 -> LOAD. The key is captured and busy=1 from the next edge; done drops on that edge.
- LOAD (1 cycle): write w[0..NK-1] from key; counter i=NK; rcon=8'h01.
- EXPAND: one word per cycle, i = NK..NW-1.
  - temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon = xtime(rcon), i.e. shift left 1, XOR 8'h1b if bit 7 was set.
  - Else if NK==8 and i mod NK == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - After writing w[NW-1] -> DONE.
- i mod NK is tracked with a wrapping sub-counter (0..NK-1), not a divider.
- Latency: start edge to done=1 is 1 + (NW-NK) cycles: 41 / 47 / 53 for 128/192/256.
- DONE: busy=0, done=1. Holds until reset or a new start.
- start while busy=1 is ignored: no restart, no effect on key.
- start in DONE restarts expansion. done=0 and rk_valid=0 from the next edge until the new schedule completes.
- Read port: each cycle round_key <= {w[4k],w[4k+1],w[4k+2],w[4k+3]} with k=rk_idx, and rk_valid <= done & (rk_idx <= NR).
  - rk_idx > NR gives round_key=0 and rk_valid=0.
  - When done=0, round_key holds its previous value and rk_valid=0.
- Reset asserted mid-expansion aborts immediately to the reset state. No partial done is ever signalled.
- No combinational path from any input to any output.

Test Plan:
- KEY_BITS=128, key=2b7e151628aed2a6abf7158809cf4f3c, start pulse -> busy for 41 cycles, then done=1.
  - rk_idx=0 gives 2b7e151628aed2a6abf7158809cf4f3c.
  - rk_idx=1 gives a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; each with rk_valid=1 one cycle after the index.
- KEY_BITS=192, key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 47 cycles; rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 53 cycles; rk_idx=14 gives fe4890d1e6188d0b046df344706c631e, which exercises the i mod 8 == 4 SubWord path.
- KEY_BITS=128:
  - Second start pulse 10 cycles into expansion -> ignored; done at the original cycle 41 with the original key's schedule.
  - rk_idx=11 after done -> rk_valid=0, round_key=0.
- Reset driven low at cycle 20 of expansion -> busy=0, done=0, round_key=0 asynchronously. A new start then yields correct round 10 after 41 cycles.
- Restart from DONE with key=000102030405060708090a0b0c0d0e0f -> done drops the next cycle and returns after 41 cycles; rk_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
